// File: rtl/square_calculator.sv
// Sequential shift-and-add squarer: one partial product per clock, result held until the next completion.
// Optional build macro SQUARE_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module square_calculator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   operand,
  output logic                    busy,
  output logic [2*DATA_WIDTH-1:0] square_out,
  output logic                    cal_done
);

  localparam int RW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [RW-1:0]       a_shift;
  logic [RW-1:0]       acc;
  logic [DATA_WIDTH-1:0] mult;
  logic [CW-1:0]       count;

  logic finish;
  logic load;
  logic step;
  logic done_d;

  // Finish edge: every multiplier bit consumed, or (optionally) nothing left to add.
`ifdef SQUARE_EARLY_EXIT_EN
  assign finish = (count == CW'(DATA_WIDTH)) || (mult == '0);
`else
  assign finish = (count == CW'(DATA_WIDTH));
`endif

  assign busy = (state_q == CALC);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (finish) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_shift    <= '0;
      acc        <= '0;
      mult       <= '0;
      count      <= '0;
      square_out <= '0;
      cal_done   <= 1'b0;
    end else begin
      cal_done <= done_d;
      if (load) begin
        a_shift <= RW'(operand);
        mult    <= operand;
        acc     <= '0;
        count   <= '0;
      end else if (step) begin
        acc     <= acc + (mult[0] ? a_shift : '0);
        a_shift <= a_shift << 1;
        mult    <= mult >> 1;
        count   <= count + 1'b1;
      end
      if (done_d) begin
        square_out <= acc;
      end
    end
  end

endmodule

// File: tb/tb_square_calculator.sv
// Directed bench for square_calculator (DATA_WIDTH=16); latencies follow SQUARE_EARLY_EXIT_EN if defined.
module tb_square_calculator;

  localparam int DW = 16;
`ifdef SQUARE_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk;
  logic            rstn;
  logic            start;
  logic [DW-1:0]   operand;
  logic            busy;
  logic [2*DW-1:0] square_out;
  logic            cal_done;

  int n_vec  = 0;
  int n_fail = 0;

  square_calculator #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .operand   (operand),
    .busy      (busy),
    .square_out(square_out),
    .cal_done  (cal_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Steps edge by edge after E0; lat is the edge index (from E0) whose following cycle shows cal_done.
  task automatic wait_done(input int max_cyc, input int inject_k, output int lat, output int busy_bad);
    lat      = -1;
    busy_bad = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (cal_done) begin
        lat = k;
        return;
      end
      if (!busy) busy_bad++;
      if (k == inject_k) begin
        start   = 1'b1;
        operand = 16'd5;
      end else if (k == inject_k + 1) begin
        start   = 1'b0;
        operand = '0;
      end
    end
  endtask

  task automatic run_square(input string tag, input logic [DW-1:0] op, input logic [2*DW-1:0] exp,
                            input int lat_base, input int lat_early);
    int lat, bad;
    @(negedge clk);
    start   = 1'b1;
    operand = op;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    operand = ~op;
    check({tag, "_busy_after_e0"}, busy, 1);
    wait_done(40, -1, lat, bad);
    check({tag, "_latency"}, lat, EARLY ? lat_early : lat_base);
    check({tag, "_result"}, square_out, exp);
    check({tag, "_busy_gaps"}, bad, 0);
    check({tag, "_busy_with_done"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, cal_done, 0);
  endtask

  initial begin
    int lat, bad, spurious;
    rstn    = 1'b0;
    start   = 1'b0;
    operand = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", cal_done, 0);
    check("reset_square", square_out, 0);
    @(negedge clk);
    rstn = 1'b1;

    run_square("ffff", 16'hFFFF, 32'hFFFE0001, 17, 17);
    run_square("three", 16'd3, 32'd9, 17, 3);
    run_square("zero", 16'd0, 32'd0, 17, 1);

    // A second start at E0+4 must be dropped, not queued.
    @(negedge clk);
    start   = 1'b1;
    operand = 16'd256;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    check("ign_busy_after_e0", busy, 1);
    wait_done(40, 3, lat, bad);
    check("ign_latency", lat, EARLY ? 10 : 17);
    check("ign_result", square_out, 32'd65536);
    check("ign_busy_gaps", bad, 0);
    start    = 1'b0;
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (cal_done || busy) spurious++;
    end
    check("ign_no_queued_run", spurious, 0);
    check("ign_result_held", square_out, 32'd65536);

    // Reset in the middle of a computation.
    @(negedge clk);
    start   = 1'b1;
    operand = 16'd1000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", cal_done, 0);
    check("rst_mid_square", square_out, 0);
    @(negedge clk);
    rstn     = 1'b1;
    spurious = 0;
    repeat (25) begin
      @(negedge clk);
      if (cal_done || busy) spurious++;
    end
    check("rst_no_done_after", spurious, 0);
    run_square("thousand", 16'd1000, 32'd1000000, 17, 11);

    // start held across the cal_done cycle: 7 then 9 back-to-back.
    @(negedge clk);
    start   = 1'b1;
    operand = 16'd7;
    @(posedge clk);
    @(negedge clk);
    check("b2b_busy_first", busy, 1);
    wait_done(40, -1, lat, bad);
    check("b2b_first_latency", lat, EARLY ? 4 : 17);
    check("b2b_first_result", square_out, 32'd49);
    operand = 16'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_restart_busy", busy, 1);
    check("b2b_restart_done_low", cal_done, 0);
    wait_done(40, -1, lat, bad);
    check("b2b_second_latency", lat, EARLY ? 5 : 17);
    check("b2b_second_result", square_out, 32'd81);
    check("b2b_busy_gaps", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
